// File: rtl/food_placer_if.sv
// Request/response and body-read-port signals between the snake core and the food placer.
interface food_placer_if;
  logic       Req;
  logic [3:0] Length;
  logic [3:0] BodyIdx;
  logic [7:0] BodyLoc;
  logic [7:0] Food;
  logic       Done;
  logic       Busy;

  // Core side drives requests and answers body reads.
  modport master (
    output Req, Length, BodyLoc,
    input  BodyIdx, Food, Done, Busy
  );

  // Placer side.
  modport slave (
    input  Req, Length, BodyLoc,
    output BodyIdx, Food, Done, Busy
  );
endinterface

// File: rtl/food_placer.sv
// Picks a free 16x16 grid cell for new food: LFSR seed, then serial body scan
// with linear probing past occupied cells.
module food_placer #(
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter logic [7:0] FOOD_INIT = 8'h88
) (
  input logic           Clk,
  input logic           Reset,
  food_placer_if.slave  bus
);

  localparam int unsigned CELL_W = 8;
  localparam int unsigned IDX_W  = 4;

  // An all-zero seed would lock the LFSR, so it is replaced by 01.
  localparam logic [CELL_W-1:0] SEED_LOAD = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t            r_state;
  logic [CELL_W-1:0] r_lfsr;
  logic [CELL_W-1:0] r_cand;
  logic [CELL_W-1:0] r_food;
  logic [IDX_W-1:0]  r_body_idx;
  logic [IDX_W-1:0]  r_len;
  logic              r_done;
  logic              r_busy;

  logic              w_fb;
  logic              w_match;
  logic              w_last;

  assign w_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_match = (bus.BodyLoc == r_cand);
  assign w_last  = (r_body_idx == (r_len - IDX_W'(1)));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_lfsr     <= SEED_LOAD;
      r_cand     <= '0;
      r_food     <= FOOD_INIT;
      r_body_idx <= '0;
      r_len      <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_lfsr <= {r_lfsr[CELL_W-2:0], w_fb};
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.Req) begin
            if (bus.Length == '0) begin
              r_food <= r_lfsr;
              r_done <= 1'b1;
            end else begin
              r_cand     <= r_lfsr;
              r_body_idx <= '0;
              r_len      <= bus.Length;
              r_busy     <= 1'b1;
              r_state    <= SCAN;
            end
          end
        end
        SCAN: begin
          // A hit restarts the full body scan with the next candidate cell.
          if (w_match) begin
            r_cand     <= r_cand + CELL_W'(1);
            r_body_idx <= '0;
          end else if (!w_last) begin
            r_body_idx <= r_body_idx + IDX_W'(1);
          end else begin
            r_food     <= r_cand;
            r_done     <= 1'b1;
            r_body_idx <= '0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.BodyIdx = r_body_idx;
  assign bus.Food    = r_food;
  assign bus.Done    = r_done;
  assign bus.Busy    = r_busy;

endmodule
